// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode encoding and
// the counter width helper.
package usr_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } usr_mode_e;

  // Enough bits to hold the value WIDTH.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/usr_bit_cell.sv
// One bit of the universal shift register: 4:1 next-state mux feeding a
// single flip-flop with synchronous active-low reset and clock enable.
module usr_bit_cell
  import usr_pkg::*;
#(
  parameter logic RST_BIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       shr_in,
  input  logic       shl_in,
  input  logic       pin_bit,
  output logic       q_o
);

  logic bit_d;
  logic bit_q;

  // NOTE: bit_d is assigned on every path, starting from a default, so no latch is inferred.
  always_comb begin
    bit_d = bit_q;
    case (usr_mode_e'(mode))
      MODE_SHR:  bit_d = shr_in;
      MODE_SHL:  bit_d = shl_in;
      MODE_LOAD: bit_d = pin_bit;
      default:   bit_d = bit_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every cell samples neighbours' old values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_q <= RST_BIT;
    end else if (en) begin
      bit_q <= bit_d;
    end
  end

  assign q_o = bit_q;

endmodule

// File: rtl/univ_shift_reg_param.sv
// Parametrised universal shift register with shift counter and frame pulse.
// Optional rotate input enabled by defining USR_ROTATE_EN.
module univ_shift_reg_param
  import usr_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [1:0]                 mode,
  input  logic                       sin_r,
  input  logic                       sin_l,
`ifdef USR_ROTATE_EN
  input  logic                       rot,
`endif
  input  logic [WIDTH-1:0]           pin,
  output logic [WIDTH-1:0]           q,
  output logic                       sout_r,
  output logic                       sout_l,
  output logic [cnt_w(WIDTH)-1:0]    shift_cnt,
  output logic                       frame_done
);

  localparam int            CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] q_q;
  logic             sr_in;
  logic             sl_in;
  logic [CW-1:0]    cnt_d, cnt_q;
  logic             done_d, done_q;

`ifdef USR_ROTATE_EN
  // Rotation feeds the bit leaving the register back into the vacated end.
  assign sr_in = rot ? q_q[0]       : sin_r;
  assign sl_in = rot ? q_q[WIDTH-1] : sin_l;
`else
  assign sr_in = sin_r;
  assign sl_in = sin_l;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic shr_src;
    logic shl_src;

    if (i == WIDTH - 1) begin : g_msb
      assign shr_src = sr_in;
    end else begin : g_mid_r
      assign shr_src = q_q[i+1];
    end

    if (i == 0) begin : g_lsb
      assign shl_src = sl_in;
    end else begin : g_mid_l
      assign shl_src = q_q[i-1];
    end

    usr_bit_cell #(
      .RST_BIT (RST_VAL[i])
    ) u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .mode    (mode),
      .shr_in  (shr_src),
      .shl_in  (shl_src),
      .pin_bit (pin[i]),
      .q_o     (q_q[i])
    );
  end

  // Counts shifts in either direction; the final shift of a frame wraps to 0.
  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (en) begin
      case (usr_mode_e'(mode))
        MODE_SHR, MODE_SHL: begin
          if (cnt_q == LAST) begin
            cnt_d  = '0;
            done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        MODE_LOAD: cnt_d = '0;
        default:   cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign q          = q_q;
  assign sout_r     = q_q[0];
  assign sout_l     = q_q[WIDTH-1];
  assign shift_cnt  = cnt_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_univ_shift_reg_param.sv
// Directed self-checking bench for univ_shift_reg_param (WIDTH=4; rotate
// case on a WIDTH=8 instance when USR_ROTATE_EN is defined).
module tb_univ_shift_reg_param;

  logic       clk = 1'b0;
  logic       rst_n, en, sin_r, sin_l;
  logic [1:0] mode;
  logic [3:0] pin;
  logic [3:0] q;
  logic       sout_r, sout_l, frame_done;
  logic [2:0] shift_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

`ifdef USR_ROTATE_EN
  logic       rot = 1'b0;
  logic       rst8_n, en8, rot8;
  logic [1:0] mode8;
  logic [7:0] pin8, q8;
  logic       sout_r8, sout_l8, done8;
  logic [3:0] cnt8;
`endif

  univ_shift_reg_param #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .mode       (mode),
    .sin_r      (sin_r),
    .sin_l      (sin_l),
`ifdef USR_ROTATE_EN
    .rot        (rot),
`endif
    .pin        (pin),
    .q          (q),
    .sout_r     (sout_r),
    .sout_l     (sout_l),
    .shift_cnt  (shift_cnt),
    .frame_done (frame_done)
  );

`ifdef USR_ROTATE_EN
  univ_shift_reg_param #(.WIDTH(8)) dut8 (
    .clk        (clk),
    .rst_n      (rst8_n),
    .en         (en8),
    .mode       (mode8),
    .sin_r      (1'b0),
    .sin_l      (1'b0),
    .rot        (rot8),
    .pin        (pin8),
    .q          (q8),
    .sout_r     (sout_r8),
    .sout_l     (sout_l8),
    .shift_cnt  (cnt8),
    .frame_done (done8)
  );
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [3:0] eq,
                              input logic [2:0] ecnt, input logic edone);
    check({tag, ".q"},    q,          eq);
    check({tag, ".cnt"},  shift_cnt,  ecnt);
    check({tag, ".done"}, frame_done, edone);
  endtask

  // sin_r sequence and expected q/cnt/done after each shift-right edge.
  logic [3:0] t2_sin  = 4'b1101;  // bit k = sin_r for edge k+1
  logic [3:0] t2_q[4]   = '{4'b1000, 4'b0100, 4'b1010, 4'b1101};
  logic [2:0] t2_cnt[4] = '{3'd1, 3'd2, 3'd3, 3'd0};

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 2'b00;
    sin_r = 1'b0; sin_l = 1'b0; pin = 4'h0;
`ifdef USR_ROTATE_EN
    rst8_n = 1'b0; en8 = 1'b0; rot8 = 1'b0; mode8 = 2'b00; pin8 = 8'h00;
`endif

    // 1: reset, then hold
    step(); step();
    expect_state("rst", 4'b0000, 3'd0, 1'b0);
    rst_n = 1'b1; en = 1'b1; mode = 2'b00;
    step();
    expect_state("hold", 4'b0000, 3'd0, 1'b0);

    // 2: shift right 1,0,1,1 with frame pulse on edge 4 only
    mode = 2'b01;
    for (int k = 0; k < 4; k++) begin
      sin_r = t2_sin[k];
      step();
      expect_state($sformatf("shr%0d", k + 1), t2_q[k], t2_cnt[k], k == 3);
    end
    check("shr.sout_r", sout_r, 1'b1);
    check("shr.sout_l", sout_l, 1'b1);
    mode = 2'b00;
    step();
    expect_state("shr_hold", 4'b1101, 3'd0, 1'b0);

    // 3: load A, shift left twice with sin_l=0
    mode = 2'b11; pin = 4'hA;
    step();
    expect_state("load", 4'hA, 3'd0, 1'b0);
    mode = 2'b10; sin_l = 1'b0;
    step();
    expect_state("shl1", 4'h4, 3'd1, 1'b0);
    step();
    expect_state("shl2", 4'h8, 3'd2, 1'b0);

    // 4: enable gap mid-frame; load clears the count left over from test 3
    mode = 2'b11; pin = 4'h0;
    step();
    expect_state("ld0", 4'h0, 3'd0, 1'b0);
    mode = 2'b01; sin_r = 1'b1;
    step(); step();
    expect_state("gap_pre", 4'b1100, 3'd2, 1'b0);
    en = 1'b0; sin_r = 1'b0; pin = 4'hF;
    for (int k = 0; k < 3; k++) begin
      step();
      expect_state($sformatf("gap%0d", k), 4'b1100, 3'd2, 1'b0);
    end
    en = 1'b1;
    step();
    expect_state("gap_s3", 4'b0110, 3'd3, 1'b0);
    step();
    expect_state("gap_s4", 4'b0011, 3'd0, 1'b1);

    // 5: reset mid-frame discards the partial count
    mode = 2'b11; pin = 4'h0;
    step();
    mode = 2'b01; sin_r = 1'b1;
    step(); step();
    expect_state("mid_pre", 4'b1100, 3'd2, 1'b0);
    rst_n = 1'b0;
    step();
    expect_state("mid_rst", 4'b0000, 3'd0, 1'b0);
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("post_rst%0d.done", k), frame_done, k == 4);
    end
    expect_state("post_rst", 4'b1111, 3'd0, 1'b1);
    check("post_rst.sout_l", sout_l, 1'b1);

    // Back-to-back frame: next pulse exactly 4 shifts later, direction mixed
    sin_r = 1'b0; sin_l = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      mode = (k == 2) ? 2'b10 : 2'b01;
      step();
      check($sformatf("b2b%0d.done", k), frame_done, k == 4);
    end
    // 1111 ->shr 0111 ->shl 1110 ->shr 0111 ->shr 0011
    expect_state("b2b", 4'b0011, 3'd0, 1'b1);

`ifdef USR_ROTATE_EN
    // 6: rotate right of 8'h81 on the 8-bit instance
    step();
    rst8_n = 1'b1; en8 = 1'b1; mode8 = 2'b11; pin8 = 8'h81;
    step();
    check("rot.load", q8, 8'h81);
    mode8 = 2'b01; rot8 = 1'b1; pin8 = 8'h00;
    begin
      logic [7:0] exp8[8] = '{8'hC0, 8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03, 8'h81};
      for (int k = 0; k < 8; k++) begin
        step();
        check($sformatf("rot%0d.q", k + 1), q8, exp8[k]);
        check($sformatf("rot%0d.done", k + 1), done8, k == 7);
      end
    end
    check("rot.cnt", cnt8, 4'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
